dsi_word_packer: RTL

- Packs the captured MIPI DSI byte stream (sys_clk domain) into framed 32-bit words.
- Writes them into the output FIFO that the HSPI sender drains in 4096-byte packets.
- Each burst between SOP and EOP is written as: one header word, the packed data words, then one trailer word carrying the byte count and error flags.
- The host uses these words to rebuild burst boundaries after HSPI packetization.

---
 rtl/dsi_word_packer_pkg.sv | 24 ++
 rtl/dsi_word_packer.sv | 120 ++++++++++++
 2 files changed

// File: rtl/dsi_word_packer_pkg.sv
// dsi_word_packer_pkg: shared constants, state encoding and saturating increment
// for the DSI word packer.
package dsi_word_packer_pkg;

    localparam logic [15:0] HDR_MAGIC_DEF = 16'hB5B5;
    localparam logic [7:0]  TRL_MAGIC_DEF = 8'hEE;

    // Trailer flag bit positions
    localparam int OVF_BIT    = 23;
    localparam int SOPERR_BIT = 22;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_FLUSH,
        ST_TRAILER,
        ST_GAP
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dsi_word_packer.sv
// dsi_word_packer: packs a framed DSI byte stream into header/data/trailer 32-bit FIFO words.
//
// Ports:
//   sys_clk, sys_rst_n      clock, asynchronous active-low reset
//   capture_en              gates a burst; sampled only on its SOP byte
//   rx_valid/rx_data        input byte stream, rx_sop/rx_eop mark burst edges
//   rx_ready                byte accepted when rx_valid && rx_ready
//   fifo_wr_en/fifo_wr_data registered FIFO write strobe and word
//   fifo_full               FIFO full; a write while full is a lost word
//   drop_cnt                saturating count of lost words
//   burst_seq               sequence number carried by the last header
module dsi_word_packer
    import dsi_word_packer_pkg::*;
#(
    parameter logic [15:0] HDR_MAGIC = HDR_MAGIC_DEF,
    parameter logic [7:0]  TRL_MAGIC = TRL_MAGIC_DEF
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        capture_en,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_sop,
    input  logic        rx_eop,
    output logic        rx_ready,
    output logic        fifo_wr_en,
    output logic [31:0] fifo_wr_data,
    input  logic        fifo_full,
    output logic [15:0] drop_cnt,
    output logic [7:0]  burst_seq
);

    state_t      state;
    logic [15:0] byte_count;
    logic [31:0] lanes;
    logic [1:0]  lane_idx;
    logic        sop_err;
    logic        ovf;
    logic        accept;
    logic        drop;
    logic [31:0] packed_word;
    logic [31:0] trailer_word;

    assign rx_ready    = (state == ST_IDLE) || (state == ST_DATA);
    assign accept      = rx_valid && rx_ready;
    assign drop        = fifo_wr_en && fifo_full;
    // Lanes are cleared after every emitted word, so unused lanes stay zero.
    assign packed_word = lanes | ({24'h0, rx_data} << {lane_idx, 3'b000});

    // A drop happening in the same cycle the trailer is built still lands in it.
    always_comb begin
        trailer_word             = {TRL_MAGIC, 8'h00, byte_count};
        trailer_word[OVF_BIT]    = ovf || drop;
        trailer_word[SOPERR_BIT] = sop_err;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= ST_IDLE;
            byte_count   <= '0;
            lanes        <= '0;
            lane_idx     <= '0;
            sop_err      <= 1'b0;
            ovf          <= 1'b0;
            drop_cnt     <= '0;
            burst_seq    <= '0;
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
        end else begin
            fifo_wr_en <= 1'b0;
            if (drop) begin
                drop_cnt <= sat_inc16(drop_cnt);
                ovf      <= 1'b1;
            end
            case (state)
                ST_IDLE: if (accept && rx_sop && capture_en) begin
                    fifo_wr_en   <= 1'b1;
                    fifo_wr_data <= {HDR_MAGIC, 8'h00, burst_seq + 8'd1};
                    burst_seq    <= burst_seq + 8'd1;
                    byte_count   <= 16'd1;
                    sop_err      <= 1'b0;
                    ovf          <= 1'b0;
                    lanes        <= {24'h0, rx_data};
                    lane_idx     <= 2'd1;
                    state        <= rx_eop ? ST_FLUSH : ST_DATA;
                end
                ST_DATA: if (accept) begin
                    byte_count <= sat_inc16(byte_count);
                    if (rx_sop)
                        sop_err <= 1'b1;
                    if (rx_eop || lane_idx == 2'd3) begin
                        fifo_wr_en   <= 1'b1;
                        fifo_wr_data <= packed_word;
                        lanes        <= '0;
                    end else begin
                        lanes <= packed_word;
                    end
                    lane_idx <= rx_eop ? 2'd0 : lane_idx + 2'd1;
                    if (rx_eop)
                        state <= ST_TRAILER;
                end
                ST_FLUSH: begin
                    fifo_wr_en   <= 1'b1;
                    fifo_wr_data <= lanes;
                    lanes        <= '0;
                    lane_idx     <= '0;
                    state        <= ST_TRAILER;
                end
                ST_TRAILER: begin
                    fifo_wr_en   <= 1'b1;
                    fifo_wr_data <= trailer_word;
                    state        <= ST_GAP;
                end
                ST_GAP:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
